// File: rtl/dds_cmd_parser_if.sv
// Byte-stream link from the UART DMA receive path into the DDS command parser.
interface dds_cmd_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/dds_cmd_parser.sv
// Receive-side frame decoder for the PC-to-DDS control link: header hunt, length check and
// a 24-byte payload unpacked into two DDS channel configurations committed atomically.
module dds_cmd_parser #(
   parameter int unsigned P_LEN_FIELD      = 22,
   parameter int unsigned P_TIMEOUT_CYCLES = 50000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   dds_cmd_parser_if.slave        rx_if,
   output logic                   o_dds1_run,
   output logic                   o_dds2_run,
   output logic [2:0]             o_dds1_type,
   output logic [2:0]             o_dds2_type,
   output logic [23:0]            o_dds1_frq,
   output logic [23:0]            o_dds2_frq,
   output logic [15:0]            o_dds1_amp,
   output logic [15:0]            o_dds2_amp,
   output logic [15:0]            o_dds1_offset,
   output logic [15:0]            o_dds2_offset,
   output logic [15:0]            o_dds1_pha,
   output logic [15:0]            o_dds2_pha,
   output logic [15:0]            o_dds1_duty,
   output logic [15:0]            o_dds2_duty,
   output logic                   o_cfg_valid,
   output logic                   o_frame_err,
   output logic [1:0]             o_err_code
);
   localparam int unsigned CntW     = $clog2(P_TIMEOUT_CYCLES + 1);
   localparam int          PayBytes = 24;
   localparam logic [CntW-1:0] CntMax   = CntW'(P_TIMEOUT_CYCLES);
   localparam logic [15:0]     LenField = 16'(P_LEN_FIELD);
   localparam logic [4:0]      LastIdx  = 5'(PayBytes - 1);

   typedef enum logic [2:0] {StH0, StH1, StH2, StH3, StLenHi, StLenLo, StPay} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      idx_q, idx_d;
   logic [7:0]      len_hi_q;
   // The final payload byte is taken straight from the bus at commit, so it is never buffered.
   logic [7:0]      shadow_q [PayBytes-1];
   logic            byte_v;
   logic [7:0]      byte_d;
   logic            tmo, len_err, commit;
   logic            unused_nibbles;

   assign byte_v = rx_if.rx_valid;
   assign byte_d = rx_if.rx_data;
   assign unused_nibbles = ^{shadow_q[0][7:4], shadow_q[12][7:4]};

   // Decode strobes; a byte in the would-be timeout cycle suppresses the timeout.
   always_comb begin
      tmo     = 1'b0;
      len_err = 1'b0;
      commit  = 1'b0;
      if (state_q != StH0 && !byte_v && cnt_q == CntMax) tmo = 1'b1;
      if (byte_v && state_q == StLenLo && {len_hi_q, byte_d} != LenField) len_err = 1'b1;
      if (byte_v && state_q == StPay && idx_q == LastIdx) commit = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      if (tmo) begin
         state_d = StH0;
      end else if (byte_v) begin
         case (state_q)
            StH0:    if (byte_d == 8'h00) state_d = StH1;
            StH1:    state_d = (byte_d == 8'h00) ? StH2 : StH0;
            StH2: begin
               if (byte_d == 8'h01)      state_d = StH3;
               else if (byte_d != 8'h00) state_d = StH0;
            end
            StH3: begin
               if (byte_d == 8'h01)      state_d = StLenHi;
               else if (byte_d == 8'h00) state_d = StH1;
               else                      state_d = StH0;
            end
            StLenHi: state_d = StLenLo;
            StLenLo: state_d = len_err ? StH0 : StPay;
            StPay:   if (commit) state_d = StH0;
            default: state_d = StH0;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == StH0 || byte_v) cnt_d = '0;
      else if (cnt_q != CntMax)      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (state_q == StLenLo)            idx_d = '0;
      else if (state_q == StPay && byte_v) idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= StH0;
         cnt_q         <= '0;
         idx_q         <= '0;
         len_hi_q      <= '0;
         o_cfg_valid   <= 1'b0;
         o_frame_err   <= 1'b0;
         o_err_code    <= '0;
         o_dds1_run    <= 1'b0;
         o_dds1_type   <= '0;
         o_dds1_frq    <= '0;
         o_dds1_amp    <= '0;
         o_dds1_offset <= '0;
         o_dds1_pha    <= '0;
         o_dds1_duty   <= '0;
         o_dds2_run    <= 1'b0;
         o_dds2_type   <= '0;
         o_dds2_frq    <= '0;
         o_dds2_amp    <= '0;
         o_dds2_offset <= '0;
         o_dds2_pha    <= '0;
         o_dds2_duty   <= '0;
         for (int i = 0; i < PayBytes - 1; i++) shadow_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         o_cfg_valid <= commit;
         o_frame_err <= len_err | tmo;
         if (len_err)  o_err_code <= 2'd1;
         else if (tmo) o_err_code <= 2'd2;
         if (byte_v && state_q == StLenHi) len_hi_q <= byte_d;
         if (byte_v && state_q == StPay && idx_q != LastIdx) shadow_q[idx_q] <= byte_d;
         if (commit) begin
            o_dds1_run    <= shadow_q[0][3];
            o_dds1_type   <= shadow_q[0][2:0];
            o_dds1_frq    <= {shadow_q[1], shadow_q[2], shadow_q[3]};
            o_dds1_amp    <= {shadow_q[4], shadow_q[5]};
            o_dds1_offset <= {shadow_q[6], shadow_q[7]};
            o_dds1_pha    <= {shadow_q[8], shadow_q[9]};
            o_dds1_duty   <= {shadow_q[10], shadow_q[11]};
            o_dds2_run    <= shadow_q[12][3];
            o_dds2_type   <= shadow_q[12][2:0];
            o_dds2_frq    <= {shadow_q[13], shadow_q[14], shadow_q[15]};
            o_dds2_amp    <= {shadow_q[16], shadow_q[17]};
            o_dds2_offset <= {shadow_q[18], shadow_q[19]};
            o_dds2_pha    <= {shadow_q[20], shadow_q[21]};
            o_dds2_duty   <= {shadow_q[22], byte_d};
         end
      end
   end
endmodule
